// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One bit is retired per cycle; a final FIX cycle applies sign correction and writes HI/LO.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] x_r;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] rem_r;   // product high half or partial remainder
  logic [WIDTH-1:0] quo_r;   // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0] rs_r;
  logic             neg_a_r, neg_b_r, is_div_r, dbz_r;

  logic [WIDTH-1:0]   abs_rs_s, abs_rt_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   next_rem_s, next_quo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;

  // Operand magnitudes for signed ops (op[0]==0 selects signed).
  always_comb begin
    abs_rs_s = rs;
    abs_rt_s = rt;
    if (!op[0] && rs[WIDTH-1]) abs_rs_s = {WIDTH{1'b0}} - rs;
    else                       abs_rs_s = rs;
    if (!op[0] && rt[WIDTH-1]) abs_rt_s = {WIDTH{1'b0}} - rt;
    else                       abs_rt_s = rt;
  end

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    mul_sum_s   = {1'b0, rem_r};
    if (quo_r[0]) mul_sum_s = {1'b0, rem_r} + {1'b0, x_r};
    else          mul_sum_s = {1'b0, rem_r};
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, x_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - x_r;
    if (is_div_r) begin
      next_rem_s = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
      next_quo_s = {quo_r[WIDTH-2:0], div_ge_s};
    end else begin
      next_rem_s = mul_sum_s[WIDTH:1];
      next_quo_s = {mul_sum_s[0], quo_r[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    prod_s     = {rem_r, quo_r};
    prod_fix_s = (neg_a_r ^ neg_b_r) ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    quo_fix_s  = (neg_a_r ^ neg_b_r) ? ({WIDTH{1'b0}} - quo_r) : quo_r;
    rem_fix_s  = neg_a_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
    if (is_div_r && dbz_r) begin
      res_hi_s = rs_r;
      res_lo_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      rs_r        <= {WIDTH{1'b0}};
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      is_div_r    <= 1'b0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                neg_a_r  <= !op[0] && rs[WIDTH-1];
                neg_b_r  <= !op[0] && rt[WIDTH-1];
                is_div_r <= op[1];
                dbz_r    <= op[1] && (rt == {WIDTH{1'b0}});
                rs_r     <= rs;
                x_r      <= op[1] ? abs_rt_s : abs_rs_s;
                quo_r    <= op[1] ? abs_rs_s : abs_rt_s;
                rem_r    <= {WIDTH{1'b0}};
                cnt_r    <= {CW{1'b0}};
                state_r  <= RUN;
                busy     <= 1'b1;
              end
              3'b100:  hi <= rs;
              3'b101:  lo <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            rem_r <= next_rem_s;
            quo_r <= next_quo_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == LAST) state_r <= FIX;
          end
        end
        FIX: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          if (!flush) begin
            hi          <= res_hi_s;
            lo          <= res_lo_s;
            done        <= 1'b1;
            div_by_zero <= dbz_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (WIDTH=32).
module tb_mips_muldiv;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs = 32'd0, rt = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int          tests_run = 0, tests_failed = 0;
  int          lat, bcnt, dcnt;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done (bounded) and cycles with busy high.
  task automatic wait_done(output int k, output int bc);
    k = 0; bc = 0;
    while (k < 100 && !done) begin
      if (busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, want 0", busy, done, div_by_zero, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    @(negedge clk);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    tests_run++;
    if (lat !== 33 || bcnt !== 33) begin
      tests_failed++;
      $display("FAIL multu_latency: lat=%0d busy_cycles=%0d, want 33/33", lat, bcnt);
    end
    tests_run++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b dbz=%b, want fffffffe/00000001/0/0", hi, lo, busy, div_by_zero);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_mult();
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bcnt);
    tests_run++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL mult_neg: hi=%h lo=%h, want ffffffff/ffffffeb", hi, lo);
    end
    @(negedge clk);
    issue(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9);
    wait_done(lat, bcnt);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'h0000_0015 || lat !== 33) begin
      tests_failed++;
      $display("FAIL mult_negneg: hi=%h lo=%h lat=%0d, want 0/15/33", hi, lo, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_div();
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    tests_run++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_neg: lo=%h hi=%h dbz=%b, want fffffffd/ffffffff/0", lo, hi, div_by_zero);
    end
    @(negedge clk);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    tests_run++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_overflow: lo=%h hi=%h dbz=%b, want 80000000/0/0", lo, hi, div_by_zero);
    end
    @(negedge clk);
    issue(DIVU, 32'd50, 32'd7);
    wait_done(lat, bcnt);
    tests_run++;
    if (lo !== 32'd7 || hi !== 32'd1) begin
      tests_failed++;
      $display("FAIL divu: lo=%h hi=%h, want 7/1", lo, hi);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    issue(DIVU, 32'd100, 32'd0);
    wait_done(lat, bcnt);
    tests_run++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0064 || div_by_zero !== 1'b1 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL divu_zero: lo=%h hi=%h dbz=%b done=%b, want ffffffff/64/1/1", lo, hi, div_by_zero, done);
    end
    @(negedge clk);
    tests_run++;
    if (div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbz_clear: dbz=%b, want 0", div_by_zero);
    end
    issue(DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat, bcnt);
    tests_run++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB || div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_zero_signed: lo=%h hi=%h dbz=%b, want ffffffff/fffffffb/1", lo, hi, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_mthi_and_busy_start();
    issue(MTHI, 32'h0000_1234, 32'd0);
    tests_run++;
    if (hi !== 32'h0000_1234 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h busy=%b done=%b, want 1234/0/0", hi, busy, done);
    end
    issue(MTLO, 32'h0000_0055, 32'd0);
    issue(MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    issue(MTLO, 32'h0000_00AA, 32'd0);
    tests_run++;
    if (lo !== 32'h0000_0055 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mtlo_while_busy: lo=%h busy=%b, want 55/1", lo, busy);
    end
    wait_done(lat, bcnt);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'h0000_000F) begin
      tests_failed++;
      $display("FAIL multu_small: hi=%h lo=%h, want 0/f", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    // Still in the done cycle of the previous operation.
    issue(MULTU, 32'd6, 32'd7);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    wait_done(lat, bcnt);
    tests_run++;
    if (lat !== 33 || lo !== 32'h0000_002A || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_result: lat=%0d hi=%h lo=%h, want 33/0/2a", lat, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    issue(DIVU, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midop: busy=%b hi=%h lo=%h done=%b, want 0/0/0/0", busy, hi, lo, done);
    end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests_run++;
    if (dcnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: done pulses=%0d, want 0", dcnt);
    end
    issue(MTHI, 32'h0000_BEEF, 32'd0);
    issue(MTLO, 32'h0000_CAFE, 32'd0);
    issue(DIVU, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0000_BEEF || lo !== 32'h0000_CAFE) begin
      tests_failed++;
      $display("FAIL flush_midop: busy=%b hi=%h lo=%h, want 0/beef/cafe", busy, hi, lo);
    end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests_run++;
    if (dcnt !== 0 || hi !== 32'h0000_BEEF || lo !== 32'h0000_CAFE) begin
      tests_failed++;
      $display("FAIL flush_no_done: done pulses=%0d hi=%h lo=%h, want 0/beef/cafe", dcnt, hi, lo);
    end
    flush = 1'b1;
    issue(MTHI, 32'h0000_1111, 32'd0);
    flush = 1'b0;
    tests_run++;
    if (hi !== 32'h0000_BEEF || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_with_start: hi=%h busy=%b, want beef/0", hi, busy);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_and_busy_start();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
